// File: rtl/sincos_pkg.sv
// sincos_pkg: shared definitions for the sine/cosine generator.
//   - state_e     : sequencer states
//   - QUAD0..3    : quadrant codes taken from the top two angle bits
//   - CORE_FRAC_W : fractional precision of the quarter-wave polynomial
//   - COEF_A/B/C  : polynomial coefficients, unsigned Q1.30
//   - fold_sel()  : per-quadrant phase reflection and sign selection
package sincos_pkg;

    typedef enum logic [1:0] {StIdle, StSin, StCos, StDone} state_e;

    localparam logic [1:0] QUAD0 = 2'd0;
    localparam logic [1:0] QUAD1 = 2'd1;
    localparam logic [1:0] QUAD2 = 2'd2;
    localparam logic [1:0] QUAD3 = 2'd3;

    localparam int unsigned CORE_FRAC_W = 30;

    // sin(pi/2*x) ~= x*(A - x^2*(B - C*x^2)), x in [0,1].
    // A = pi/2; B and C chosen so that A-B+C == 1.0 exactly (in LSBs) and
    // the slope at x=1 is zero, so phase Q yields exactly full scale.
    localparam logic [30:0] COEF_A = 31'd1686629713;
    localparam logic [30:0] COEF_B = 31'd688904866;
    localparam logic [30:0] COEF_C = 31'd76016977;

    typedef struct packed {
        logic reflect;  // use Q-r instead of r
        logic neg;      // negate the magnitude
    } fold_t;

    function automatic fold_t fold_sel(input logic [1:0] quad, input logic is_cos);
        fold_t f;
        f.reflect = 1'b0;
        f.neg     = 1'b0;
        case (quad)
            QUAD0: begin f.reflect = is_cos;  f.neg = 1'b0;    end
            QUAD1: begin f.reflect = !is_cos; f.neg = is_cos;  end
            QUAD2: begin f.reflect = is_cos;  f.neg = 1'b1;    end
            QUAD3: begin f.reflect = !is_cos; f.neg = !is_cos; end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/quarter_sine.sv
// quarter_sine: pipelined quarter-wave magnitude, mag = sin(pi/2 * phase/Q)
// scaled so that phase Q gives 2^(DATA_W-2). Latency is CORE_LAT cycles.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   phase_i  in   [ANGLE_W-2:0] phase, 0..Q inclusive (Q = 2^(ANGLE_W-2))
//   mag_o    out  [DATA_W-2:0] unsigned magnitude
module quarter_sine import sincos_pkg::*; #(
    parameter int unsigned ANGLE_W  = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ANGLE_W-2:0]  phase_i,
    output logic [DATA_W-2:0]   mag_o
);

    localparam int unsigned FW = CORE_FRAC_W;
    localparam logic [FW:0] ONE = (FW+1)'(1) << FW;

    logic [FW:0]     x, x2_d, x_q, x2_q;
    logic [63:0]     prod_xx;
    logic [63:0]     prod_c, prod_b, prod_a;
    logic [FW:0]     t1, t2, t3, t4, t5, poly;
    logic [DATA_W-2:0] mag_c;

    // Phase to Q1.30 fraction of a quarter turn.
    assign x       = (FW+1)'({phase_i, {FW{1'b0}}} >> (ANGLE_W-2));
    assign prod_xx = 64'(x) * 64'(x);
    assign x2_d    = (FW+1)'(prod_xx >> FW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            x2_q <= '0;
        end else begin
            x_q  <= x;
            x2_q <= x2_d;
        end
    end

    // Horner evaluation; every intermediate stays within [0, 2^31).
    always_comb begin
        prod_c = 64'(COEF_C) * 64'(x2_q);
        t1     = (FW+1)'(prod_c >> FW);
        t2     = COEF_B - t1;
        prod_b = 64'(t2) * 64'(x2_q);
        t3     = (FW+1)'(prod_b >> FW);
        t4     = COEF_A - t3;
        prod_a = 64'(t4) * 64'(x_q);
        t5     = (FW+1)'(prod_a >> FW);
        // Truncation can nudge the peak a hair past 1.0.
        poly   = (t5 > ONE) ? ONE : t5;
    end

    // Rescale Q1.30 to the output format (1.0 = 2^(DATA_W-2)).
    assign mag_c = (DATA_W-1)'(({{(DATA_W+1){1'b0}}, poly} << (DATA_W-2)) >> FW);

    if (CORE_LAT > 1) begin : g_delay
        logic [DATA_W-2:0] dly_q [CORE_LAT-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(CORE_LAT) - 1; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= mag_c;
                for (int i = 1; i < int'(CORE_LAT) - 1; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign mag_o = dly_q[CORE_LAT-2];
    end else begin : g_nodelay
        assign mag_o = mag_c;
    end

endmodule

// File: rtl/sincos_seq.sv
// sincos_seq: handshaked sine/cosine generator. Folds the angle into the
// first quadrant, evaluates magnitudes on the quarter-wave core, applies
// the quadrant sign and returns a registered signed pair plus tag.
// Build option: define SINCOS_DUAL_CORE_EN for two parallel cores (sine and
// cosine computed together, COS state skipped); otherwise one shared core.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   in_valid/in_ready request handshake; in_angle, in_id sampled on accept
//   out_valid/out_ready result handshake; out_sin, out_cos, out_id held
//                      stable while out_valid && !out_ready
module sincos_seq import sincos_pkg::*; #(
    parameter int unsigned ANGLE_W  = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ANGLE_W-1:0] in_angle,
    input  logic [ID_W-1:0]    in_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sin,
    output logic [DATA_W-1:0]  out_cos,
    output logic [ID_W-1:0]    out_id
);

    localparam int unsigned PH_W  = ANGLE_W - 1;
    localparam int unsigned CNT_W = $clog2(CORE_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT);
    localparam logic [CNT_W-1:0] COS_LAST = CNT_W'(CORE_LAT - 1);
    localparam logic [PH_W-1:0]  QUARTER  = PH_W'(1) << (ANGLE_W - 2);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ANGLE_W-1:0]   angle_q, angle_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [DATA_W-1:0]    sin_q, sin_d, cos_q, cos_d;

    logic [1:0]           quad;
    logic [PH_W-1:0]      r_ext, sin_phase, cos_phase;
    fold_t                sin_fold, cos_fold;
    logic [DATA_W-2:0]    sin_mag, cos_mag;
    logic [DATA_W-1:0]    sin_ext, cos_ext, sin_signed, cos_signed;

    assign quad      = angle_q[ANGLE_W-1:ANGLE_W-2];
    assign r_ext     = {1'b0, angle_q[ANGLE_W-3:0]};
    assign sin_fold  = fold_sel(quad, 1'b0);
    assign cos_fold  = fold_sel(quad, 1'b1);
    assign sin_phase = sin_fold.reflect ? (QUARTER - r_ext) : r_ext;
    assign cos_phase = cos_fold.reflect ? (QUARTER - r_ext) : r_ext;

`ifdef SINCOS_DUAL_CORE_EN
    quarter_sine #(.ANGLE_W(ANGLE_W), .DATA_W(DATA_W), .CORE_LAT(CORE_LAT)) u_core_sin (
        .clk     (clk),
        .rst_n   (rst_n),
        .phase_i (sin_phase),
        .mag_o   (sin_mag)
    );
    quarter_sine #(.ANGLE_W(ANGLE_W), .DATA_W(DATA_W), .CORE_LAT(CORE_LAT)) u_core_cos (
        .clk     (clk),
        .rst_n   (rst_n),
        .phase_i (cos_phase),
        .mag_o   (cos_mag)
    );
`else
    logic [PH_W-1:0]   core_phase;
    logic [DATA_W-2:0] core_mag;

    // Sine phase is issued on SIN cycles 0..CORE_LAT-1. On the last SIN cycle
    // (where the sine emerges) the cosine phase is already issued, so the
    // pipelined core overlaps the two evaluations by one cycle.
    assign core_phase = (state_q == StSin && cnt_q != CNT_LAST) ? sin_phase : cos_phase;

    quarter_sine #(.ANGLE_W(ANGLE_W), .DATA_W(DATA_W), .CORE_LAT(CORE_LAT)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .phase_i (core_phase),
        .mag_o   (core_mag)
    );
    assign sin_mag = core_mag;
    assign cos_mag = core_mag;
`endif

    assign sin_ext    = {1'b0, sin_mag};
    assign cos_ext    = {1'b0, cos_mag};
    assign sin_signed = sin_fold.neg ? -sin_ext : sin_ext;
    assign cos_signed = cos_fold.neg ? -cos_ext : cos_ext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        angle_d   = angle_q;
        id_d      = id_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    angle_d = in_angle;
                    id_d    = in_id;
                    cnt_d   = '0;
                    state_d = StSin;
                end
            end
            StSin: begin
                if (cnt_q == CNT_LAST) begin
                    sin_d   = sin_signed;
                    cnt_d   = '0;
`ifdef SINCOS_DUAL_CORE_EN
                    cos_d   = cos_signed;
                    state_d = StDone;
`else
                    state_d = StCos;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCos: begin
                if (cnt_q == COS_LAST) begin
                    cos_d   = cos_signed;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            angle_q <= '0;
            id_q    <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            id_q    <= id_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
        end
    end

    assign out_sin = sin_q;
    assign out_cos = cos_q;
    assign out_id  = id_q;

endmodule

// File: tb/tb_sincos_seq.sv
// tb_sincos_seq: self-checking bench for sincos_seq (default parameters).
// Directed table for the quadrant boundaries, hand-written sequences for
// back-pressure and mid-operation reset, then a shuffled full-angle sweep
// with random out_ready checked against a real-arithmetic sin/cos model.
module tb_sincos_seq;

    localparam int ANGLE_W  = 12;
    localparam int DATA_W   = 32;
    localparam int ID_W     = 4;
    localparam int CORE_LAT = 2;
`ifdef SINCOS_DUAL_CORE_EN
    localparam int LAT = CORE_LAT + 1;
`else
    localparam int LAT = 2 * CORE_LAT + 1;
`endif
    localparam int  NANG  = 4096;
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = 1073741824.0;
    localparam real TOL   = 1.0e-3 * 1073741824.0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ANGLE_W-1:0] in_angle = '0;
    logic [ID_W-1:0]   in_id = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_sin, out_cos;
    logic [ID_W-1:0]   out_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sincos_seq #(
        .ANGLE_W  (ANGLE_W),
        .DATA_W   (DATA_W),
        .ID_W     (ID_W),
        .CORE_LAT (CORE_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .in_id     (in_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sin   (out_sin),
        .out_cos   (out_cos),
        .out_id    (out_id)
    );

    typedef struct {
        logic [ANGLE_W-1:0] angle;
        logic [ID_W-1:0]    id;
        logic [DATA_W-1:0]  exp_sin;
        logic [DATA_W-1:0]  exp_cos;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int a, input logic [DATA_W-1:0] act,
                              input real exp);
        real d;
        checks++;
        d = real'($signed(act)) - exp;
        if (d < 0.0) d = -d;
        if (d > TOL) begin
            errors++;
            $display("FAIL %s angle 0x%03h: got %0d, want %0.1f +/- %0.1f",
                     name, a, $signed(act), exp, TOL);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no handshake, want one within bound", name);
    endtask

    function automatic real ref_val(input int a, input bit is_cos);
        real ph;
        ph = 2.0 * PI * real'(a) / real'(NANG);
        return (is_cos ? $cos(ph) : $sin(ph)) * SCALE;
    endfunction

    function automatic logic [DATA_W-1:0] ref_exact(input real v);
        int iv;
        iv = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        return DATA_W'(iv);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns #1 after the accept edge.
    task automatic request(input logic [ANGLE_W-1:0] a, input logic [ID_W-1:0] id);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        in_valid = 1'b1;
        in_angle = a;
        in_id    = id;
        while (!rdy && n < 200) begin
            rdy = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_angle = ANGLE_W'($urandom);
        in_id    = ID_W'($urandom);
        if (!rdy) timeout_fail("accept");
    endtask

    // Counts edges until out_valid is seen high.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   lat;
        int   order[NANG];
        logic [DATA_W-1:0] sin_res[NANG];
        logic [DATA_W-1:0] cos_res[NANG];
        bit   seen[NANG];
        logic [ANGLE_W-1:0] exp_a[$];
        logic [ID_W-1:0]    exp_id[$];
        int   got;

        vecs[0] = '{angle: 12'h000, id: 4'd3,  exp_sin: 32'h0000_0000, exp_cos: 32'h4000_0000};
        vecs[1] = '{angle: 12'h400, id: 4'd10, exp_sin: 32'h4000_0000, exp_cos: 32'h0000_0000};
        vecs[2] = '{angle: 12'h800, id: 4'd15, exp_sin: 32'h0000_0000, exp_cos: 32'hC000_0000};
        vecs[3] = '{angle: 12'hC00, id: 4'd1,  exp_sin: 32'hC000_0000, exp_cos: 32'h0000_0000};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_out_sin", 64'(out_sin), 64'd0);
        check("rst_out_cos", 64'(out_cos), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Directed quadrant boundaries
        for (int i = 0; i < 4; i++) begin
            request(vecs[i].angle, vecs[i].id);
            check("busy_in_ready", 64'(in_ready), 64'd0);
            wait_result(lat);
            check("latency", 64'(lat), 64'(LAT));
            check("vec_sin", 64'(out_sin), 64'(vecs[i].exp_sin));
            check("vec_cos", 64'(out_cos), 64'(vecs[i].exp_cos));
            check("vec_id", 64'(out_id), 64'(vecs[i].id));
            handshake();
            check("post_hs_valid", 64'(out_valid), 64'd0);
            check("post_hs_ready", 64'(in_ready), 64'd1);
        end

        // Back-pressure with a second request pending
        request(12'h400, 4'd5);
        wait_result(lat);
        check("hold_latency", 64'(lat), 64'(LAT));
        in_valid = 1'b1;
        in_angle = 12'h800;
        in_id    = 4'd6;
        for (int i = 0; i < 10; i++) begin
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_sin", 64'(out_sin), 64'h4000_0000);
            check("hold_cos", 64'(out_cos), 64'd0);
            check("hold_id", 64'(out_id), 64'd5);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("second_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_result(lat);
        check("second_latency", 64'(lat), 64'(LAT));
        check("second_sin", 64'(out_sin), 64'd0);
        check("second_cos", 64'(out_cos), 64'hC000_0000);
        check("second_id", 64'(out_id), 64'd6);
        handshake();

        // Reset in the middle of a request (COS state in the single-core build)
        request(12'h200, 4'd7);
        repeat (LAT - CORE_LAT) tick();
        rst_n = 1'b0;
        #2;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_sin", 64'(out_sin), 64'd0);
        check("midrst_cos", 64'(out_cos), 64'd0);
        check("midrst_id", 64'(out_id), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        request(12'hC00, 4'd9);
        wait_result(lat);
        check("postrst_latency", 64'(lat), 64'(LAT));
        check("postrst_sin", 64'(out_sin), 64'hC000_0000);
        check("postrst_cos", 64'(out_cos), 64'd0);
        check("postrst_id", 64'(out_id), 64'd9);
        handshake();

        // Shuffled sweep of every angle, back-to-back, random out_ready
        for (int i = 0; i < NANG; i++) begin
            order[i] = i;
            seen[i]  = 1'b0;
        end
        for (int i = NANG - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        got = 0;
        fork
            begin : producer
                for (int k = 0; k < NANG; k++) begin
                    int   n;
                    logic rdy;
                    logic [ID_W-1:0] id;
                    if ($urandom_range(0, 7) == 0) begin
                        in_valid = 1'b0;
                        tick();
                    end
                    id = ID_W'($urandom);
                    in_valid = 1'b1;
                    in_angle = ANGLE_W'(order[k]);
                    in_id    = id;
                    n = 0;
                    rdy = 1'b0;
                    while (!rdy && n < 200) begin
                        rdy = in_ready;
                        tick();
                        n++;
                    end
                    if (!rdy) begin
                        timeout_fail("sweep_accept");
                        break;
                    end
                    exp_a.push_back(ANGLE_W'(order[k]));
                    exp_id.push_back(id);
                end
                in_valid = 1'b0;
            end
            begin : consumer
                int idle;
                idle = 0;
                while (got < NANG && idle < 300) begin
                    logic vld, rdy;
                    logic [DATA_W-1:0] s, c;
                    logic [ID_W-1:0]   id;
                    rdy = 1'($urandom_range(0, 1));
                    out_ready = rdy;
                    vld = out_valid;
                    s   = out_sin;
                    c   = out_cos;
                    id  = out_id;
                    tick();
                    if (vld && rdy) begin
                        idle = 0;
                        if (exp_a.size() == 0) begin
                            timeout_fail("sweep_unexpected_result");
                        end else begin
                            int a;
                            logic [ID_W-1:0] eid;
                            a   = int'(exp_a.pop_front());
                            eid = exp_id.pop_front();
                            check("sweep_id", 64'(id), 64'(eid));
                            check_near("sweep_sin", a, s, ref_val(a, 1'b0));
                            check_near("sweep_cos", a, c, ref_val(a, 1'b1));
                            if (a % (NANG / 4) == 0) begin
                                check("sweep_sin_exact", 64'(s), 64'(ref_exact(ref_val(a, 1'b0))));
                                check("sweep_cos_exact", 64'(c), 64'(ref_exact(ref_val(a, 1'b1))));
                            end
                            sin_res[a] = s;
                            cos_res[a] = c;
                            seen[a]    = 1'b1;
                        end
                        got++;
                    end else begin
                        idle++;
                    end
                end
                out_ready = 1'b0;
                if (got < NANG) timeout_fail("sweep_result");
            end
        join
        check("sweep_count", 64'(got), 64'(NANG));

        // Half-turn symmetry: f(a) == -f(a + half turn)
        for (int a = 0; a < NANG / 2; a++) begin
            if (seen[a] && seen[a + NANG / 2]) begin
                logic [DATA_W-1:0] ns, nc;
                ns = -sin_res[a + NANG / 2];
                nc = -cos_res[a + NANG / 2];
                check("sym_sin", 64'(sin_res[a]), 64'(ns));
                check("sym_cos", 64'(cos_res[a]), 64'(nc));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
